// File: rtl/stream_source.sv
// Valid/ready traffic source: emits an incrementing pattern starting at SEED,
// with a programmable idle gap after each accepted beat and an optional beat limit.
module stream_source #(
    parameter int unsigned    DW        = 16,
    parameter int unsigned    DELAY     = 1,
    parameter int unsigned    NUM_BEATS = 0,
    parameter logic [DW-1:0]  SEED      = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [31:0]   beat_cnt_o,
    output logic [1:0]    state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [31:0] DELAY_L = 32'(DELAY);
    localparam logic [31:0] NUM_L   = 32'(NUM_BEATS);

    logic [1:0]  state;
    logic [31:0] gap_cnt;
    logic        stop_pend;
    logic        handshake;
    logic [31:0] cnt_next;

    // A beat transfers on any rising edge where valid_o and ready_i are both high;
    // once valid_o rises, it and data_o hold until that transfer happens.
    assign handshake = valid_o && ready_i;
    assign cnt_next  = beat_cnt_o + 32'd1;

    assign valid_o = (state == S_SEND);
    assign busy_o  = (state == S_SEND) || (state == S_GAP);
    assign done_o  = (state == S_DONE);
    assign state_o = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            data_o     <= SEED;
            beat_cnt_o <= '0;
            gap_cnt    <= '0;
            stop_pend  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i && !stop_i) begin
                        state      <= S_SEND;
                        data_o     <= SEED;
                        beat_cnt_o <= '0;
                        stop_pend  <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (handshake) begin
                        beat_cnt_o <= cnt_next;
                        data_o     <= data_o + DW'(1);
                        if ((NUM_L != 32'd0) && (cnt_next == NUM_L)) begin
                            state     <= S_DONE;
                            stop_pend <= 1'b0;
                        end else if (stop_i || stop_pend) begin
                            state     <= S_IDLE;
                            stop_pend <= 1'b0;
                        end else if (DELAY_L == 32'd0) begin
                            state <= S_SEND;
                        end else begin
                            state   <= S_GAP;
                            gap_cnt <= DELAY_L;
                        end
                    end else if (stop_i) begin
                        // Stop is deferred so the presented beat is never withdrawn.
                        stop_pend <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (stop_i || stop_pend) begin
                        state     <= S_IDLE;
                        stop_pend <= 1'b0;
                        gap_cnt   <= '0;
                    end else if (gap_cnt <= 32'd1) begin
                        state   <= S_SEND;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
